// File: rtl/dest_merge.sv
// rtl/dest_merge.sv - per-destination merge: one-deep source slots, round-robin drain, output FIFO
module dest_merge #(
  parameter int PORT_NUB_TOTAL = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int DEST           = 0,
  parameter int DEPTH          = 8,
  localparam int WIDTH_SEL     = $clog2(PORT_NUB_TOTAL),
  localparam int WIDTH_WORD    = 2*WIDTH_SEL + DATA_WIDTH,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [PORT_NUB_TOTAL*WIDTH_WORD-1:0] port_in,
  input  logic [PORT_NUB_TOTAL-1:0]            port_vaild,
  output logic [WIDTH_WORD-1:0]                out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [AW:0]                          fifo_count,
  output logic [15:0]                          drop_cnt,
  output logic                                 overflow
);

  // DEST only has to agree with the upstream filter; rx_port is never re-checked here.
  if (DEST < 0 || DEST >= PORT_NUB_TOTAL) begin : g_bad_dest
    $error("dest_merge: DEST out of range");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dest_merge: DEPTH must be a power of two >= 2");
  end

  logic [PORT_NUB_TOTAL-1:0] slot_full;
  logic [WIDTH_WORD-1:0]     slot_word [PORT_NUB_TOTAL];
  logic [WIDTH_SEL-1:0]      rr_ptr;

  logic [WIDTH_WORD-1:0]     mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;

  logic                      found;
  logic [WIDTH_SEL-1:0]      pick;
  logic                      grant;
  logic [PORT_NUB_TOTAL-1:0] granted;
  logic                      pop;
  logic                      fifo_wr_ok;
  logic [PORT_NUB_TOTAL-1:0] drop_vec;
  logic [WIDTH_SEL:0]        drop_num;
  logic [16:0]               drop_sum;

  assign out_valid  = (fifo_count != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign pop        = out_valid & out_ready;
  assign fifo_wr_ok = (fifo_count < (AW+1)'(DEPTH)) | pop;

  // Round-robin pick: lowest full slot at or above rr_ptr, else lowest full slot below it.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = PORT_NUB_TOTAL-1; i >= 0; i--) begin
      if (slot_full[i] && (WIDTH_SEL'(i) < rr_ptr)) begin
        found = 1'b1;
        pick  = WIDTH_SEL'(i);
      end
    end
    // Second pass overrides the wrap candidate whenever an upper candidate exists.
    for (int i = PORT_NUB_TOTAL-1; i >= 0; i--) begin
      if (slot_full[i] && (WIDTH_SEL'(i) >= rr_ptr)) begin
        found = 1'b1;
        pick  = WIDTH_SEL'(i);
      end
    end
  end

  assign grant   = found & fifo_wr_ok;
  assign granted = grant ? (PORT_NUB_TOTAL'(1) << pick) : '0;

  // A word is lost when its slot is still occupied and not being drained this cycle.
  always_comb begin
    drop_num = '0;
    for (int i = 0; i < PORT_NUB_TOTAL; i++) begin
      drop_vec[i] = port_vaild[i] & slot_full[i] & ~granted[i];
      drop_num    = drop_num + (WIDTH_SEL+1)'(drop_vec[i]);
    end
    drop_sum = {1'b0, drop_cnt} + 17'(drop_num);
  end

  // Slot capture, refill-on-grant and clear-on-grant.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < PORT_NUB_TOTAL; i++) begin
        slot_full[i] <= 1'b0;
        slot_word[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PORT_NUB_TOTAL; i++) begin
        if (port_vaild[i] && (!slot_full[i] || granted[i])) begin
          slot_full[i] <= 1'b1;
          slot_word[i] <= port_in[i*WIDTH_WORD +: WIDTH_WORD];
        end else if (granted[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer advances past the granted source, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (pick == WIDTH_SEL'(PORT_NUB_TOTAL-1)) ? '0 : pick + 1'b1;
    end
  end

  // Drop statistics: saturating counter plus sticky flag.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop_vec != '0) begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      overflow <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset because out_data is masked while empty.
  always_ff @(posedge clk) begin
    if (grant) begin
      mem[wr_ptr] <= slot_word[pick];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (grant) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({grant, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dest_merge.sv
// tb/tb_dest_merge.sv - scoreboard bench for dest_merge with a queue-based reference model
module tb_dest_merge;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int DEST  = 2;
  localparam int WS    = 2;
  localparam int WW    = 2*WS + DW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N*WW-1:0] port_in = '0;
  logic [N-1:0]    port_vaild = '0;
  logic            out_ready = 1'b0;
  logic [WW-1:0]   out_data;
  logic            out_valid;
  logic [3:0]      fifo_count;
  logic [15:0]     drop_cnt;
  logic            overflow;

  always #5 clk = ~clk;

  dest_merge #(.PORT_NUB_TOTAL(N), .DATA_WIDTH(DW), .DEST(DEST), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .port_in(port_in), .port_vaild(port_vaild),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [WW-1:0] sb [$];
  logic [DW-1:0] dat [N];
  logic [WS-1:0] rxp [N];

  bit            mfull [N];
  logic [WW-1:0] mword [N];
  int            mrr;
  int            mcount;
  int            mdrop;
  bit            movf;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one cycle of slot/arbiter/FIFO behaviour written from the rules.
  task automatic model_step(input logic [N-1:0] v, input logic rdy, input logic rst,
                            input logic [WW-1:0] w [N]);
    bit pop;
    bit wr_ok;
    int g;
    if (rst) begin
      for (int i = 0; i < N; i++) mfull[i] = 0;
      sb.delete();
      mrr = 0; mcount = 0; mdrop = 0; movf = 0;
      return;
    end
    pop   = (mcount > 0) && rdy;
    wr_ok = (mcount < DEPTH) || pop;
    g = -1;
    if (wr_ok) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && mfull[(mrr + k) % N]) g = (mrr + k) % N;
      end
    end
    if (g >= 0) begin
      sb.push_back(mword[g]);
      mcount++;
      mrr = (g + 1) % N;
    end
    if (pop) mcount--;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        if (!mfull[i] || i == g) begin
          mfull[i] = 1; mword[i] = w[i];
        end else begin
          if (mdrop < 16'hFFFF) mdrop++;
          movf = 1;
        end
      end else if (i == g) begin
        mfull[i] = 0;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic rdy, input logic rst);
    logic [WW-1:0] w [N];
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      w[i] = {rxp[i], WS'(i), dat[i]};
      port_in[i*WW +: WW] = w[i];
    end
    port_vaild = v;
    out_ready  = rdy;
    rst_n      = rst;
    model_step(v, rdy, rst, w);
    @(posedge clk);
    #1;
    chk("fifo_count", fifo_count, mcount);
    chk("out_valid", out_valid, (mcount != 0));
    chk("drop_cnt", drop_cnt, mdrop);
    chk("overflow", overflow, movf);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) step('0, rdy, 1'b0);
  endtask

  // Monitor: every handshake must deliver the oldest expected word.
  initial begin
    logic [WW-1:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("pop_with_nothing_expected", out_valid, 0);
        end else begin
          exp = sb.pop_front();
          chk("out_data", out_data, exp);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      dat[i] = '0;
      rxp[i] = WS'(DEST);
    end

    // Reset state.
    step('0, 1'b1, 1'b1);
    step('0, 1'b1, 1'b1);
    chk("rst_out_data", out_data, 0);

    // Single word: source 1, A5.
    idle(2, 1'b1);
    dat[1] = 8'hA5;
    step(4'b0010, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, {WS'(DEST), WS'(1), 8'hA5});
    step('0, 1'b1, 1'b0);
    chk("single_count_back", fifo_count, 0);

    // Round robin from a fresh pointer, then wrap check.
    step('0, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) dat[i] = 8'h10 + DW'(i);
    step(4'b1111, 1'b1, 1'b0);
    idle(6, 1'b1);
    for (int i = 0; i < N; i++) dat[i] = 8'h20 + DW'(i);
    step(4'b0011, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Backpressure: 9 words fill FIFO plus slot, the 10th is dropped.
    for (int k = 0; k < 10; k++) begin
      dat[0] = 8'h40 + DW'(k);
      step(4'b0001, 1'b0, 1'b0);
    end
    chk("bp_fifo_full", fifo_count, 8);
    chk("bp_drop_cnt", drop_cnt, 1);
    chk("bp_overflow", overflow, 1);
    idle(12, 1'b1);

    // Push and pop at full with slot 3 waiting.
    for (int i = 0; i < N; i++) dat[i] = 8'h60 + DW'(i);
    step(4'b1111, 1'b0, 1'b0);
    idle(4, 1'b0);
    for (int i = 0; i < N; i++) dat[i] = 8'h70 + DW'(i);
    step(4'b1111, 1'b0, 1'b0);
    idle(4, 1'b0);
    dat[3] = 8'h83;
    step(4'b1000, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    chk("full_before_pushpop", fifo_count, 8);
    step('0, 1'b1, 1'b0);
    chk("full_pushpop_count", fifo_count, 8);
    idle(12, 1'b1);

    // Refill on grant for slot 2.
    dat[2] = 8'h91;
    step(4'b0100, 1'b1, 1'b0);
    dat[2] = 8'h92;
    step(4'b0100, 1'b1, 1'b0);
    chk("refill_no_drop", drop_cnt, 1);
    idle(4, 1'b1);

    // Reset with five words buffered.
    for (int i = 0; i < N; i++) dat[i] = 8'hB0 + DW'(i);
    step(4'b1111, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    dat[0] = 8'hB8;
    step(4'b0001, 1'b0, 1'b0);
    step('0, 1'b1, 1'b1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_drop", drop_cnt, 0);
    chk("midrst_ovf", overflow, 0);
    idle(6, 1'b1);

    // Randomized traffic with varying backpressure and occasional reset.
    for (int c = 0; c < 1500; c++) begin
      logic rdy;
      logic [N-1:0] v;
      int mode;
      mode = (c / 64) % 3;
      for (int i = 0; i < N; i++) begin
        dat[i] = DW'($urandom);
        rxp[i] = WS'($urandom);
      end
      v   = N'($urandom & $urandom);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom) : ($urandom_range(0, 7) == 0);
      step(v, rdy, ($urandom_range(0, 499) == 0));
    end

    idle(20, 1'b1);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dest_merge.md
# dest_merge

Per-destination merge stage that sits directly downstream of the per-destination `filter` in the switch module. It accepts up to `PORT_NUB_TOTAL` filtered words per cycle, holds each in a one-deep per-source slot, and drains the slots round-robin, one per cycle, into a `DEPTH`-entry output FIFO. The FIFO is read with a valid/ready handshake by the shared-memory write side. The filter has no backpressure, so words that find their slot still occupied are dropped, counted and flagged.

## Interface
- `DEST`, default 0: destination port index served. Must match the upstream filter's `dest`.
- `DEPTH`, default 8: output FIFO entries. Power of two, ≥ 2.
- Derived widths: `WIDTH_SEL` = $clog2(`PORT_NUB_TOTAL`); `WIDTH_WORD` = 2*`WIDTH_SEL` + `DATA_WIDTH`. The macros come from `generate_parameter.vh`.
- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst_n`  in  1  synchronous reset, **active-high**: asserted when 1, sampled on `clk`.
- `port_in`  in  `PORT_NUB_TOTAL`*`WIDTH_WORD`  filter output. Word i is `{rx_port, tx_port, data}` at bits [(i+1)*`WIDTH_WORD`-1 : i*`WIDTH_WORD`].
- `port_vaild`  in  `PORT_NUB_TOTAL`  per-source valid from the filter, aligned with `port_in`.
- `out_data`  out  `WIDTH_WORD`  FIFO head word.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head word this cycle.
- `fifo_count`  out  $clog2(`DEPTH`)+1  current FIFO occupancy.
- `drop_cnt`  out  16  saturating count of dropped input words.
- `overflow`  out  1  sticky; set on the first drop.

## Operation
- **Slots.** Each source i has `slot_full[i]` and `slot_word[i]`.
  - Capture when `port_vaild[i]` = 1 and either the slot is empty or it is granted this cycle.
  - If the slot is full and not granted, the word is dropped: `drop_cnt` += 1, saturating at 16'hFFFF, and `overflow` is set to 1.
  - A slot that is granted and not refilled clears.
- **Arbiter.**
  - `rr_ptr` has width `WIDTH_SEL` and resets to 0.
  - Grant goes to the lowest-index full slot with index ≥ `rr_ptr`; if none, it wraps to the lowest full index below `rr_ptr`.
  - A grant is issued only when `fifo_wr_ok` = 1.
  - On a grant g, `rr_ptr` ← (g+1) mod `PORT_NUB_TOTAL`. With no grant, `rr_ptr` holds.
  - At most one grant per cycle.
- **FIFO.**
  - `fifo_wr_ok` = (`fifo_count` < `DEPTH`) OR (`out_valid` AND `out_ready`), i.e. write-at-full is allowed on the same cycle as a read.
  - A pop occurs when `out_valid` AND `out_ready`.
  - `out_valid` = (`fifo_count` != 0); `out_data` = mem[rd_ptr].
  - Pointers are $clog2(`DEPTH`) bits and wrap naturally.
  - On a simultaneous push and pop, `fifo_count` is unchanged.
  - `out_data` is don't-care when `out_valid` = 0.
- **Data integrity.** Words are never modified. `rx_port` is passed through as received; the block does not re-check `DEST`.
- **Ordering.** Words from one source leave in arrival order. Across sources, order follows the round-robin grant.

## Timing
- **Reset**, one cycle of `rst_n`=1:
  - All `slot_full` = 0, FIFO empty, `rr_ptr` = 0.
  - `out_valid` = 0, `fifo_count` = 0, `drop_cnt` = 0, `overflow` = 0, `out_data` = 0.
  - Inputs during reset are ignored.
  - Reset mid-operation discards all buffered words, without counting them as drops.
- **Latency.** `port_vaild[i]` in cycle N gives the slot full in N+1, grant and FIFO write in N+1, and `out_valid` = 1 in N+2. This assumes no contention and the FIFO not full.
- **Throughput.** One word per cycle into the FIFO and one out.
- **Burst behaviour.** A burst of `PORT_NUB_TOTAL` simultaneous words drains over `PORT_NUB_TOTAL` cycles. Any source that presents again before its slot is granted loses that word.
- **FIFO full with no pop.** No grant is issued, slots hold their words, and new inputs to full slots are dropped.
- **Timing closure.** The arbiter and FIFO write decision form a single combinational stage per cycle. There is no pipeline alignment to the filter's `PIPELINE` option: `port_in` and `port_vaild` arrive already aligned.

## Test plan
Directed scenarios, all with `PORT_NUB_TOTAL`=4, `DATA_WIDTH`=8, `DEPTH`=8, `DEST`=2:
- **Single word.** Source 1 presents data 8'hA5 with `port_vaild`=4'b0010 in cycle 5, `out_ready`=1 → `out_valid`=1 in cycle 7 with data A5, `fifo_count` back to 0 in cycle 8.
- **Round robin.** `port_vaild`=4'b1111 for one cycle, data 8'h10 to 8'h13 for sources 0 to 3 → output order 10, 11, 12, 13 on consecutive cycles. Then `port_vaild`=4'b0011 → source 0, then 1 (`rr_ptr` wrapped to 0).
- **Backpressure.** `out_ready`=0 while source 0 sends 9 words on consecutive cycles:
  - `fifo_count` reaches 8 and the 9th word waits in the slot.
  - Next word into that slot → `drop_cnt`=1, `overflow`=1.
  - Raising `out_ready` → 9 words out in order.
- **Push and pop at full.** FIFO full, `out_ready`=1, slot 3 full → grant and pop in the same cycle, `fifo_count` stays 8.
- **Refill on grant.** Slot 2 is granted while `port_vaild[2]`=1 in the same cycle → new word captured, no drop.
- **Reset mid-operation.** Assert `rst_n`=1 with 5 words buffered → next cycle `out_valid`=0, `fifo_count`=0, `drop_cnt`=0, `overflow`=0, `rr_ptr`=0. No stale word ever appears afterwards.
